ysyx_lsu: RTL and testbench
===========================

Name: ysyx_lsu

Overview:
Load/store unit front end between the execute stage and the bus arbiter's lsu:load / lsu:store port group.
- Accepts one memory request at a time from EXU.
- Checks the request's alignment and funct3 encoding.
- Drives the arbiter's ar/aw/w request signals, holding them stable until completion.
- Sign- or zero-extends load data.
- Returns one response per request to WBU, with a valid/ready handshake and perf counters.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  EXU request valid
req_ready_o  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, unshifted (bit 0 aligned)
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
rsp_valid_o  out  1  response valid to WBU
rsp_ready  in  1  WBU accepts response
rsp_rdata_o  out  DATA_W  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned or illegal funct3
lsu_araddr_o  out  ADDR_W  to arbiter lsu_araddr
lsu_arvalid_o  out  1  to arbiter lsu_arvalid
lsu_rstrb_o  out  8  to arbiter lsu_rstrb (8'h1 / 8'h3 / 8'hf)
lsu_rdata  in  DATA_W  from arbiter; already right-shifted by addr[1:0]
lsu_rvalid  in  1  from arbiter
lsu_awaddr_o  out  ADDR_W  to arbiter lsu_awaddr
lsu_awvalid_o  out  1  to arbiter lsu_awvalid
lsu_wdata_o  out  DATA_W  to arbiter lsu_wdata, unshifted
lsu_wstrb_o  out  8  to arbiter lsu_wstrb (8'h1 / 8'h3 / 8'hf)
lsu_wvalid_o  out  1  to arbiter lsu_wvalid
lsu_wready  in  1  from arbiter
perf_ld_cnt_o  out  32  completed loads
perf_st_cnt_o  out  32  completed stores
perf_wait_cyc_o  out  32  cycles spent in LOAD or STORE

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE immediately.
  - All valid outputs 0; rsp_rdata_o = 0; rsp_err_o = 0.
  - Address, data and strobe outputs 0; perf counters 0.
  - req_ready_o = 1 once in IDLE.
  - Reset mid-transaction abandons it; no response is ever produced for it.
- States: IDLE, LOAD, STORE, RESP. req_ready_o = (state == IDLE).
- IDLE: accept on req_valid & req_ready_o at a clock edge, latching addr, wdata, funct3 and wen.
  - Error if either holds:
    - illegal funct3: load 3'b011/110/111, or store funct3 > 3'b010;
    - misaligned: half-word with addr[0]=1, or word with addr[1:0]!=0.
  - On error: go to RESP with err=1 and rdata=0. No bus signal is asserted.
  - Otherwise: go to LOAD (wen=0) or STORE (wen=1).
- Strobe from size: byte=8'h1, half=8'h3, word=8'hf. Drives lsu_rstrb_o for loads and lsu_wstrb_o for stores.
- LOAD:
  - lsu_arvalid_o = 1; lsu_araddr_o = latched addr. Both held constant until lsu_rvalid is sampled high.
  - On lsu_rvalid: capture the extended data and go to RESP. arvalid drops in the following cycle.
  - Extension:
    - LB: sign-extend bit 7; LBU: zero-extend bits 7:0.
    - LH: sign-extend bit 15; LHU: zero-extend bits 15:0.
    - LW: pass through unchanged.
- STORE:
  - lsu_awvalid_o = lsu_wvalid_o = 1; address, data and strobe held constant.
  - On lsu_wready: go to RESP with rdata=0. awvalid and wvalid drop in the next cycle.
- RESP: rsp_valid_o = 1; data and err held constant until rsp_ready is high at an edge, then go to IDLE.
  - A new request cannot be accepted in the same cycle as rsp_ready; it is accepted one cycle later, in IDLE.
- Latency: accept at edge E0 → request valid visible after E0. A response sampled at edge En → rsp_valid_o high after En. Minimum load/store latency is 2 edges; error latency is 1 edge.
- lsu_rvalid or lsu_wready arriving outside LOAD/STORE is ignored.
- Perf counters, all wrapping modulo 2^32:
  - perf_ld_cnt_o / perf_st_cnt_o increment on the LOAD→RESP / STORE→RESP transition.
  - perf_wait_cyc_o increments each cycle state ∈ {LOAD, STORE}.
  - Errors count in neither load nor store counter.

Test Plan:
1. LB at 0x80000003, bus returns lsu_rdata=0x000000F0 after 3 wait cycles → arvalid held 4 cycles with araddr=0x80000003 and rstrb=8'h1; rsp_rdata_o=0xFFFFFFF0, err=0; perf_ld_cnt=1, perf_wait_cyc=4.
2. LHU at 0x80000002, lsu_rdata=0x0000ABCD → rsp_rdata_o=0x0000ABCD; same stimulus as LH → 0xFFFFABCD.
3. SW 0xDEADBEEF to 0x80001000, lsu_wready after 2 cycles → aw/wvalid high 3 cycles, wstrb=8'hf, wdata unshifted; rsp_rdata_o=0; perf_st_cnt=1.
4. LW at 0x80000002 and SH at 0x80000001 → rsp_err_o=1 one edge after accept; no ar/aw/wvalid ever asserted; counters unchanged.
5. rsp_ready held low 5 cycles → rsp_valid_o and data stable throughout; req_ready_o=0; the next request is accepted only in the cycle after the handshake.
6. Async rst low mid-LOAD, between clock edges → arvalid=0 immediately; after release: IDLE, req_ready_o=1, counters 0, no response emitted.

Source files
------------

// File: rtl/ysyx_lsu.sv
// Load/store unit front end: takes one EXU memory request at a time, checks it,
// drives the arbiter's lsu load/store port group and returns one response to WBU.
module ysyx_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // EXU request
  input  logic              req_valid,
  output logic              req_ready_o,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  // WBU response
  output logic              rsp_valid_o,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  // Arbiter load port
  output logic [ADDR_W-1:0] lsu_araddr_o,
  output logic              lsu_arvalid_o,
  output logic [7:0]        lsu_rstrb_o,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rvalid,
  // Arbiter store port
  output logic [ADDR_W-1:0] lsu_awaddr_o,
  output logic              lsu_awvalid_o,
  output logic [DATA_W-1:0] lsu_wdata_o,
  output logic [7:0]        lsu_wstrb_o,
  output logic              lsu_wvalid_o,
  input  logic              lsu_wready,
  // Performance counters
  output logic [31:0]       perf_ld_cnt_o,
  output logic [31:0]       perf_st_cnt_o,
  output logic [31:0]       perf_wait_cyc_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StResp} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        funct3_q;
  logic [7:0]        rstrb_q;
  logic [7:0]        wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [31:0]       ld_cnt_q;
  logic [31:0]       st_cnt_q;
  logic [31:0]       wait_cyc_q;

  logic              f3_illegal;
  logic              misaligned;
  logic              req_err;
  logic [7:0]        req_strb;
  logic [DATA_W-1:0] ld_ext;

  // Decode the incoming request: legality, alignment and byte strobe from size
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    req_strb   = 8'h0f;
    if (req_wen) begin
      f3_illegal = (req_funct3 > 3'b010);
    end else begin
      f3_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b00:   req_strb = 8'h01;
      2'b01: begin
        req_strb   = 8'h03;
        misaligned = req_addr[0];
      end
      default: begin
        req_strb   = 8'h0f;
        misaligned = (req_addr[1:0] != 2'b00);
      end
    endcase
    req_err = f3_illegal || misaligned;
  end

  // Sign/zero-extend the already right-aligned load data
  always_comb begin
    ld_ext = lsu_rdata;
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_W-8){lsu_rdata[7]}}, lsu_rdata[7:0]};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, lsu_rdata[7:0]};
      3'b001:  ld_ext = {{(DATA_W-16){lsu_rdata[15]}}, lsu_rdata[15:0]};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, lsu_rdata[15:0]};
      default: ld_ext = lsu_rdata;
    endcase
  end

  // Request FSM; latches the request and owns all registered response fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      rstrb_q  <= 8'h00;
      wstrb_q  <= 8'h00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            rdata_q  <= '0;
            if (req_err) begin
              // Errored requests never touch the bus
              err_q   <= 1'b1;
              rstrb_q <= 8'h00;
              wstrb_q <= 8'h00;
              state_q <= StResp;
            end else if (req_wen) begin
              err_q   <= 1'b0;
              rstrb_q <= 8'h00;
              wstrb_q <= req_strb;
              state_q <= StStore;
            end else begin
              err_q   <= 1'b0;
              rstrb_q <= req_strb;
              wstrb_q <= 8'h00;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (lsu_rvalid) begin
            rdata_q <= ld_ext;
            state_q <= StResp;
          end
        end
        StStore: begin
          if (lsu_wready) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt_q   <= 32'd0;
      st_cnt_q   <= 32'd0;
      wait_cyc_q <= 32'd0;
    end else begin
      if (state_q == StLoad && lsu_rvalid) begin
        ld_cnt_q <= ld_cnt_q + 32'd1;
      end
      if (state_q == StStore && lsu_wready) begin
        st_cnt_q <= st_cnt_q + 32'd1;
      end
      if (state_q == StLoad || state_q == StStore) begin
        wait_cyc_q <= wait_cyc_q + 32'd1;
      end
    end
  end

  assign req_ready_o     = (state_q == StIdle);
  assign rsp_valid_o     = (state_q == StResp);
  assign rsp_rdata_o     = rdata_q;
  assign rsp_err_o       = err_q;

  assign lsu_arvalid_o   = (state_q == StLoad);
  assign lsu_araddr_o    = addr_q;
  assign lsu_rstrb_o     = rstrb_q;

  assign lsu_awvalid_o   = (state_q == StStore);
  assign lsu_wvalid_o    = (state_q == StStore);
  assign lsu_awaddr_o    = addr_q;
  assign lsu_wdata_o     = wdata_q;
  assign lsu_wstrb_o     = wstrb_q;

  assign perf_ld_cnt_o   = ld_cnt_q;
  assign perf_st_cnt_o   = st_cnt_q;
  assign perf_wait_cyc_o = wait_cyc_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Self-checking bench for ysyx_lsu: scoreboard of expected responses plus a
// small reference model for errors, extension, strobes and perf counters.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready_o, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid_o, rsp_ready, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] lsu_araddr_o, lsu_rdata, lsu_awaddr_o, lsu_wdata_o;
  logic        lsu_arvalid_o, lsu_rvalid, lsu_awvalid_o, lsu_wvalid_o, lsu_wready;
  logic [7:0]  lsu_rstrb_o, lsu_wstrb_o;
  logic [31:0] perf_ld_cnt_o, perf_st_cnt_o, perf_wait_cyc_o;

  ysyx_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready_o(req_ready_o), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid_o(rsp_valid_o), .rsp_ready(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .lsu_araddr_o(lsu_araddr_o), .lsu_arvalid_o(lsu_arvalid_o), .lsu_rstrb_o(lsu_rstrb_o),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr_o(lsu_awaddr_o), .lsu_awvalid_o(lsu_awvalid_o), .lsu_wdata_o(lsu_wdata_o),
    .lsu_wstrb_o(lsu_wstrb_o), .lsu_wvalid_o(lsu_wvalid_o), .lsu_wready(lsu_wready),
    .perf_ld_cnt_o(perf_ld_cnt_o), .perf_st_cnt_o(perf_st_cnt_o),
    .perf_wait_cyc_o(perf_wait_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        sb_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          bus_seen  = 0;
  logic [31:0] exp_ld = 0, exp_st = 0, exp_wait = 0;

  // Counts any bus valid seen mid-cycle; error tests clear it and expect it to stay 0
  always @(negedge clk) begin
    if (lsu_arvalid_o || lsu_awvalid_o || lsu_wvalid_o) bus_seen = bus_seen + 1;
  end

  function automatic logic model_err(input logic wen, input logic [2:0] f3,
                                     input logic [31:0] a);
    if (wen) begin
      case (f3)
        3'b000:  return 1'b0;
        3'b001:  return a[0];
        3'b010:  return a[1:0] != 2'b00;
        default: return 1'b1;
      endcase
    end
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return a[1:0] != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      default: return 8'h0f;
    endcase
  endfunction

  task automatic check_perf(input string tag);
    total_cnt++;
    if (perf_ld_cnt_o !== exp_ld || perf_st_cnt_o !== exp_st || perf_wait_cyc_o !== exp_wait)
      $display("FAIL perf_%s: got ld=%0d st=%0d wait=%0d, required ld=%0d st=%0d wait=%0d",
               tag, perf_ld_cnt_o, perf_st_cnt_o, perf_wait_cyc_o, exp_ld, exp_st, exp_wait);
    else pass_cnt++;
  endtask

  // Pops the scoreboard on the response, optionally stalls WBU, then handshakes.
  // With chain set, a new load is presented during the handshake edge.
  task automatic take_rsp(input int hold, input bit chain);
    rsp_t        e;
    logic [31:0] snap;
    int          waited = 0;
    while (rsp_valid_o !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    total_cnt++;
    if (waited != 0 || rsp_valid_o !== 1'b1)
      $display("FAIL rsp_latency: waited %0d cycles valid=%b, required 0 cycles valid=1",
               waited, rsp_valid_o);
    else pass_cnt++;
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL sb_underflow: got response with empty scoreboard, required entry");
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    total_cnt++;
    if (rsp_rdata_o !== e.rdata || rsp_err_o !== e.err)
      $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
               rsp_rdata_o, rsp_err_o, e.rdata, e.err);
    else pass_cnt++;
    snap = rsp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== snap || rsp_err_o !== e.err ||
          req_ready_o !== 1'b0)
        $display("FAIL rsp_hold cycle %0d: got valid=%b rdata=%h err=%b req_ready=%b, required 1/%h/%b/0",
                 i, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o, snap, e.err);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    if (chain) begin
      req_valid  = 1'b1;
      req_wen    = 1'b0;
      req_addr   = 32'h8000_0100;
      req_wdata  = 32'h0;
      req_funct3 = 3'b010;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total_cnt++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || lsu_arvalid_o !== 1'b0)
      $display("FAIL rsp_done: got valid=%b req_ready=%b arvalid=%b, required 0/1/0",
               rsp_valid_o, req_ready_o, lsu_arvalid_o);
    else pass_cnt++;
  endtask

  // One complete transaction; the bus answers after `waits` stall cycles.
  task automatic run_mem(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] bdata, input int waits,
                         input int hold, input bit chain, input bit predriven);
    rsp_t       e;
    bit         err;
    logic [7:0] strb;
    err     = model_err(wen, f3, addr);
    strb    = model_strb(f3);
    e.err   = err;
    e.rdata = (err || wen) ? 32'h0 : model_ext(f3, bdata);
    sb_q.push_back(e);
    if (!predriven) begin
      total_cnt++;
      if (req_ready_o !== 1'b1)
        $display("FAIL req_ready_idle: got %b, required 1", req_ready_o);
      else pass_cnt++;
      req_valid  = 1'b1;
      req_wen    = wen;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (!err) begin
      for (int i = 0; i <= waits; i++) begin
        total_cnt++;
        if ((wen && !(lsu_awvalid_o === 1'b1 && lsu_wvalid_o === 1'b1 &&
                      lsu_arvalid_o === 1'b0 && lsu_awaddr_o === addr &&
                      lsu_wdata_o === wdata && lsu_wstrb_o === strb)) ||
            (!wen && !(lsu_arvalid_o === 1'b1 && lsu_awvalid_o === 1'b0 &&
                       lsu_wvalid_o === 1'b0 && lsu_araddr_o === addr &&
                       lsu_rstrb_o === strb)) || rsp_valid_o !== 1'b0)
          $display("FAIL bus_hold cycle %0d: got ar=%b aw=%b w=%b araddr=%h awaddr=%h wdata=%h rstrb=%h wstrb=%h rsp=%b, required wen=%b addr=%h wdata=%h strb=%h rsp=0",
                   i, lsu_arvalid_o, lsu_awvalid_o, lsu_wvalid_o, lsu_araddr_o, lsu_awaddr_o,
                   lsu_wdata_o, lsu_rstrb_o, lsu_wstrb_o, rsp_valid_o, wen, addr, wdata, strb);
        else pass_cnt++;
        if (i == waits) begin
          if (wen) lsu_wready = 1'b1;
          else begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = bdata;
          end
        end else begin
          lsu_rdata = $urandom;
        end
        @(posedge clk); #1;
        lsu_rvalid = 1'b0;
        lsu_wready = 1'b0;
        lsu_rdata  = $urandom;
      end
      exp_wait += 32'(waits + 1);
      if (wen) exp_st++;
      else     exp_ld++;
    end
    total_cnt++;
    if (lsu_arvalid_o !== 1'b0 || lsu_awvalid_o !== 1'b0 || lsu_wvalid_o !== 1'b0)
      $display("FAIL bus_drop: got ar=%b aw=%b w=%b, required 0/0/0",
               lsu_arvalid_o, lsu_awvalid_o, lsu_wvalid_o);
    else pass_cnt++;
    take_rsp(hold, chain);
    check_perf("after_txn");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || lsu_arvalid_o !== 1'b0 ||
        lsu_awvalid_o !== 1'b0 || lsu_wvalid_o !== 1'b0 || rsp_rdata_o !== 32'h0 ||
        rsp_err_o !== 1'b0 || lsu_araddr_o !== 32'h0 || lsu_awaddr_o !== 32'h0 ||
        lsu_wdata_o !== 32'h0 || lsu_rstrb_o !== 8'h0 || lsu_wstrb_o !== 8'h0)
      $display("FAIL reset_outputs: got rr=%b rv=%b ar=%b aw=%b w=%b rd=%h err=%b ara=%h awa=%h wd=%h rs=%h ws=%h, required 1 then all 0",
               req_ready_o, rsp_valid_o, lsu_arvalid_o, lsu_awvalid_o, lsu_wvalid_o,
               rsp_rdata_o, rsp_err_o, lsu_araddr_o, lsu_awaddr_o, lsu_wdata_o,
               lsu_rstrb_o, lsu_wstrb_o);
    else pass_cnt++;
    check_perf("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_lb();
    run_mem(1'b0, 32'h8000_0003, 32'h0, 3'b000, 32'h0000_00F0, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_load_ext();
    run_mem(1'b0, 32'h8000_0002, 32'h0, 3'b101, 32'h0000_ABCD, 0, 0, 1'b0, 1'b0);
    run_mem(1'b0, 32'h8000_0002, 32'h0, 3'b001, 32'h0000_ABCD, 0, 0, 1'b0, 1'b0);
    run_mem(1'b0, 32'h8000_0001, 32'h0, 3'b100, 32'h1234_5680, 1, 0, 1'b0, 1'b0);
    run_mem(1'b0, 32'h8000_0004, 32'h0, 3'b010, 32'h8765_4321, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_store();
    run_mem(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 3'b010, 32'h0, 2, 0, 1'b0, 1'b0);
    run_mem(1'b1, 32'h8000_1003, 32'h1234_56AB, 3'b000, 32'h0, 0, 0, 1'b0, 1'b0);
    run_mem(1'b1, 32'h8000_1002, 32'h0000_5A5A, 3'b001, 32'h0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    bus_seen = 0;
    run_mem(1'b0, 32'h8000_0002, 32'h0, 3'b010, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run_mem(1'b1, 32'h8000_0001, 32'h1111, 3'b001, 32'h0, 0, 0, 1'b0, 1'b0);
    run_mem(1'b0, 32'h8000_0000, 32'h0, 3'b011, 32'h0, 0, 0, 1'b0, 1'b0);
    run_mem(1'b1, 32'h8000_0000, 32'h2222, 3'b100, 32'h0, 0, 0, 1'b0, 1'b0);
    run_mem(1'b0, 32'h8000_0000, 32'h0, 3'b110, 32'h0, 0, 1, 1'b0, 1'b0);
    total_cnt++;
    if (bus_seen != 0) $display("FAIL err_no_bus: got %0d bus-valid cycles, required 0", bus_seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_mem(1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'h1122_3344, 0, 5, 1'b1, 1'b0);
    run_mem(1'b0, 32'h8000_0100, 32'h0, 3'b010, 32'hCAFE_F00D, 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    int bad = 0;
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_addr   = 32'h8000_0003;
    req_funct3 = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total_cnt++;
    if (lsu_arvalid_o !== 1'b1) $display("FAIL arst_pre: got arvalid=%b, required 1", lsu_arvalid_o);
    else pass_cnt++;
    #3 rst = 1'b0;
    #1;
    exp_ld = 0; exp_st = 0; exp_wait = 0;
    total_cnt++;
    if (lsu_arvalid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0)
      $display("FAIL arst_now: got arvalid=%b req_ready=%b rsp_valid=%b, required 0/1/0",
               lsu_arvalid_o, req_ready_o, rsp_valid_o);
    else pass_cnt++;
    check_perf("arst");
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    lsu_rvalid = 1'b1;
    lsu_wready = 1'b1;
    lsu_rdata  = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o !== 1'b0 || lsu_arvalid_o !== 1'b0 || req_ready_o !== 1'b1) bad++;
    end
    lsu_rvalid = 1'b0;
    lsu_wready = 1'b0;
    total_cnt++;
    if (bad != 0) $display("FAIL arst_idle: got %0d cycles with response/bus activity, required 0", bad);
    else pass_cnt++;
    check_perf("arst_idle");
    run_mem(1'b1, 32'h8000_2000, 32'h0BAD_F00D, 3'b010, 32'h0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    rsp_ready  = 1'b0;
    lsu_rdata  = 32'h0;
    lsu_rvalid = 1'b0;
    lsu_wready = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_lb();
    test_load_ext();
    test_store();
    test_errors();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
